irs_readout_sequencer: RTL and testbench

- Downstream consumer of the event controller's block-info buffer (72-bit entries).
- Pops one entry at a time, splits entries into events using the new-event flag, emits one event header per event, then drives the IRS read top one block at a time.
- Returns each read block to the IRS manager through the free interface.
- Truncates oversize events and discards orphan blocks.

---
 rtl/irs_readout_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_irs_readout_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irs_readout_sequencer.sv
// irs_readout_sequencer
// Pops block-info entries from the event controller's buffer, emits one
// event header per new_event entry, then reads and frees blocks one at a time.
// Oversize events are truncated (extra blocks freed unread) and orphan
// continuation blocks are freed without a read.
// Optional feature macro: IRS_SEQ_RD_TIMEOUT_EN adds an rd_ack watchdog and
// the timeout_o output port.
module irs_readout_sequencer #(
  parameter int MAX_BLOCKS     = 64,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [71:0] irs_buff_dat_i,
  input  logic        irs_buff_empty_i,
  output logic        irs_buff_read_o,
  output logic [63:0] ev_hdr_dat_o,
  output logic [15:0] ev_num_o,
  output logic        ev_hdr_valid_o,
  input  logic        ev_hdr_ready_i,
  output logic [8:0]  rd_block_o,
  output logic        rd_req_o,
  input  logic        rd_ack_i,
  output logic [8:0]  free_block_o,
  output logic        free_req_o,
  output logic [6:0]  ev_blocks_o,
  output logic        trunc_o,
  output logic        orphan_o,
  input  logic        err_clr_i
`ifdef IRS_SEQ_RD_TIMEOUT_EN
  ,
  output logic        timeout_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_HDR,
    S_READ,
    S_FREE
  } state_t;

  state_t      state_q, state_d;
  logic        read_q, read_d;
  logic [63:0] hdr_dat_q, hdr_dat_d;
  logic [15:0] ev_num_q, ev_num_d;
  logic        hdr_vld_q, hdr_vld_d;
  logic [8:0]  rd_block_q, rd_block_d;
  logic        rd_req_q, rd_req_d;
  logic [8:0]  free_block_q, free_block_d;
  logic        free_req_q, free_req_d;
  logic [6:0]  ev_blocks_q, ev_blocks_d;
  logic        trunc_q, trunc_d;
  logic        orphan_q, orphan_d;
  logic        open_q, open_d;
  logic [15:0] count_q, count_d;

  logic [8:0]  ent_blk;
  logic        ent_new;

  assign ent_blk = irs_buff_dat_i[8:0];
  assign ent_new = irs_buff_dat_i[9];

  // Bits [23:22] of the entry carry nothing for this block.
  logic unused_dat;
  assign unused_dat = ^irs_buff_dat_i[23:22];

`ifdef IRS_SEQ_RD_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;
  assign timeout_o = timeout_q;
`else
  logic unused_to;
  assign unused_to = ^(16'(TIMEOUT_CYCLES));
`endif

  // Block count reported to the outside saturates at the 7-bit maximum.
  function automatic logic [6:0] sat7(input logic [15:0] c);
    return (c > 16'd127) ? 7'd127 : c[6:0];
  endfunction

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    read_d       = 1'b0;
    hdr_dat_d    = hdr_dat_q;
    ev_num_d     = ev_num_q;
    hdr_vld_d    = hdr_vld_q;
    rd_block_d   = rd_block_q;
    rd_req_d     = rd_req_q;
    free_block_d = free_block_q;
    free_req_d   = 1'b0;
    ev_blocks_d  = ev_blocks_q;
    trunc_d      = trunc_q;
    orphan_d     = orphan_q;
    open_d       = open_q;
    count_d      = count_q;
`ifdef IRS_SEQ_RD_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    timeout_d    = timeout_q;
`endif

    // Clear first so that a set in the same cycle takes priority.
    if (err_clr_i) begin
      trunc_d  = 1'b0;
      orphan_d = 1'b0;
`ifdef IRS_SEQ_RD_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (!irs_buff_empty_i) begin
          read_d  = 1'b1;
          state_d = S_POP;
        end
      end
      // Buffer pops on this edge; entry is presented in the next cycle.
      S_POP: state_d = S_LATCH;
      S_LATCH: begin
        if (ent_new) begin
          hdr_dat_d = {4'h0, irs_buff_dat_i[21:16], irs_buff_dat_i[15:10],
                       irs_buff_dat_i[71:40], irs_buff_dat_i[39:24]};
          if (open_q) ev_blocks_d = sat7(count_q);
          count_d    = '0;
          open_d     = 1'b1;
          rd_block_d = ent_blk;
          hdr_vld_d  = 1'b1;
          state_d    = S_HDR;
        end else if (!open_q) begin
          orphan_d     = 1'b1;
          free_block_d = ent_blk;
          free_req_d   = 1'b1;
          state_d      = S_FREE;
        end else if (count_q == 16'(MAX_BLOCKS)) begin
          trunc_d      = 1'b1;
          free_block_d = ent_blk;
          free_req_d   = 1'b1;
          state_d      = S_FREE;
        end else begin
          rd_block_d = ent_blk;
          rd_req_d   = 1'b1;
`ifdef IRS_SEQ_RD_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
          state_d    = S_READ;
        end
      end
      S_HDR: begin
        if (ev_hdr_ready_i) begin
          hdr_vld_d = 1'b0;
          ev_num_d  = ev_num_q + 16'd1;
          rd_req_d  = 1'b1;
`ifdef IRS_SEQ_RD_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (rd_ack_i) begin
          rd_req_d     = 1'b0;
          count_d      = count_q + 16'd1;
          free_block_d = rd_block_q;
          free_req_d   = 1'b1;
          state_d      = S_FREE;
        end
`ifdef IRS_SEQ_RD_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          // Give up on this block: free it without counting it.
          rd_req_d     = 1'b0;
          timeout_d    = 1'b1;
          free_block_d = rd_block_q;
          free_req_d   = 1'b1;
          state_d      = S_FREE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end
      // Free pulse is on the outputs now; pop again straight away if possible.
      S_FREE: begin
        if (!irs_buff_empty_i) begin
          read_d  = 1'b1;
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      read_q       <= 1'b0;
      hdr_dat_q    <= '0;
      ev_num_q     <= '0;
      hdr_vld_q    <= 1'b0;
      rd_block_q   <= '0;
      rd_req_q     <= 1'b0;
      free_block_q <= '0;
      free_req_q   <= 1'b0;
      ev_blocks_q  <= '0;
      trunc_q      <= 1'b0;
      orphan_q     <= 1'b0;
      open_q       <= 1'b0;
      count_q      <= '0;
`ifdef IRS_SEQ_RD_TIMEOUT_EN
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      hdr_dat_q    <= hdr_dat_d;
      ev_num_q     <= ev_num_d;
      hdr_vld_q    <= hdr_vld_d;
      rd_block_q   <= rd_block_d;
      rd_req_q     <= rd_req_d;
      free_block_q <= free_block_d;
      free_req_q   <= free_req_d;
      ev_blocks_q  <= ev_blocks_d;
      trunc_q      <= trunc_d;
      orphan_q     <= orphan_d;
      open_q       <= open_d;
      count_q      <= count_d;
`ifdef IRS_SEQ_RD_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign irs_buff_read_o = read_q;
  assign ev_hdr_dat_o    = hdr_dat_q;
  assign ev_num_o        = ev_num_q;
  assign ev_hdr_valid_o  = hdr_vld_q;
  assign rd_block_o      = rd_block_q;
  assign rd_req_o        = rd_req_q;
  assign free_block_o    = free_block_q;
  assign free_req_o      = free_req_q;
  assign ev_blocks_o     = ev_blocks_q;
  assign trunc_o         = trunc_q;
  assign orphan_o        = orphan_q;

endmodule

// File: tb/tb_irs_readout_sequencer.sv
// Testbench for irs_readout_sequencer: buffer model, handshake drivers,
// entry-level reference model with an ordered expected-transaction queue.
module tb_irs_readout_sequencer;

  localparam int MAXB = 2;
  localparam int TOC  = 100;
  localparam int K_HDR  = 0;
  localparam int K_RD   = 1;
  localparam int K_FREE = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [71:0] irs_buff_dat_i = '0;
  logic        irs_buff_empty_i = 1'b1;
  logic        irs_buff_read_o;
  logic [63:0] ev_hdr_dat_o;
  logic [15:0] ev_num_o;
  logic        ev_hdr_valid_o;
  logic        ev_hdr_ready_i = 1'b0;
  logic [8:0]  rd_block_o;
  logic        rd_req_o;
  logic        rd_ack_i = 1'b0;
  logic [8:0]  free_block_o;
  logic        free_req_o;
  logic [6:0]  ev_blocks_o;
  logic        trunc_o;
  logic        orphan_o;
  logic        err_clr_i = 1'b0;
`ifdef IRS_SEQ_RD_TIMEOUT_EN
  logic        timeout_o;
`endif

  always #5 clk = ~clk;

  irs_readout_sequencer #(.MAX_BLOCKS(MAXB), .TIMEOUT_CYCLES(TOC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .irs_buff_dat_i(irs_buff_dat_i), .irs_buff_empty_i(irs_buff_empty_i),
    .irs_buff_read_o(irs_buff_read_o),
    .ev_hdr_dat_o(ev_hdr_dat_o), .ev_num_o(ev_num_o),
    .ev_hdr_valid_o(ev_hdr_valid_o), .ev_hdr_ready_i(ev_hdr_ready_i),
    .rd_block_o(rd_block_o), .rd_req_o(rd_req_o), .rd_ack_i(rd_ack_i),
    .free_block_o(free_block_o), .free_req_o(free_req_o),
    .ev_blocks_o(ev_blocks_o), .trunc_o(trunc_o), .orphan_o(orphan_o),
    .err_clr_i(err_clr_i)
`ifdef IRS_SEQ_RD_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  int nvec = 0;
  int nfail = 0;

  typedef struct {
    int          kind;
    logic [63:0] hdr;
    logic [15:0] num;
    logic [8:0]  blk;
    logic        tr;
    logic        orp;
    logic [6:0]  evb;
  } exp_t;

  exp_t        expq[$];
  logic [71:0] bq[$];
  logic [71:0] hold = '0;
  bit          pend = 0;
  bit          mon_en = 0;
  int          rdy_mode = 0;  // 0 always high, 1 random, 2 always low
  int          ack_mode = 0;

  bit          m_open;
  int          m_cnt;
  logic [15:0] m_evnum;
  logic [6:0]  m_evb;
  logic        m_tr, m_orp;

  function automatic void model_reset();
    m_open = 0; m_cnt = 0; m_evnum = '0; m_evb = '0; m_tr = 0; m_orp = 0;
    expq.delete();
  endfunction

  function automatic void add_exp(input int k, input logic [63:0] h, input logic [8:0] b);
    exp_t x;
    x.kind = k; x.hdr = h; x.num = m_evnum; x.blk = b;
    x.tr = m_tr; x.orp = m_orp; x.evb = m_evb;
    expq.push_back(x);
  endfunction

  // Entry-level rules: what transactions one popped entry must produce.
  function automatic void model_entry(input logic [71:0] e);
    logic [8:0] b;
    b = e[8:0];
    if (e[9]) begin
      if (m_open) m_evb = (m_cnt > 127) ? 7'd127 : 7'(m_cnt);
      m_cnt = 0;
      m_open = 1;
      add_exp(K_HDR, {4'h0, e[21:16], e[15:10], e[71:40], e[39:24]}, b);
      m_evnum = m_evnum + 16'd1;
      add_exp(K_RD, '0, b);
      m_cnt++;
      add_exp(K_FREE, '0, b);
    end else if (!m_open) begin
      m_orp = 1;
      add_exp(K_FREE, '0, b);
    end else if (m_cnt >= MAXB) begin
      m_tr = 1;
      add_exp(K_FREE, '0, b);
    end else begin
      add_exp(K_RD, '0, b);
      m_cnt++;
      add_exp(K_FREE, '0, b);
    end
  endfunction

  function automatic logic [71:0] mk_entry(input logic [8:0] blk, input logic nw,
                                           input logic [15:0] sec, input logic [31:0] cyc);
    return {cyc, sec, 2'b00, 6'd0, 6'd0, nw, blk};
  endfunction

  function automatic void push_entry(input logic [71:0] e);
    bq.push_back(e);
    model_entry(e);
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Non-FWFT buffer and handshake drivers, all updated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        irs_buff_dat_i = hold;
        pend = 0;
      end
      if (irs_buff_read_o && !rst_i) begin
        nvec++;
        if (bq.size() == 0) begin
          nfail++;
          $display("FAIL pop_empty got read=1 want read=0 while buffer empty");
        end else begin
          hold = bq.pop_front();
          pend = 1;
        end
      end
      irs_buff_empty_i = (bq.size() == 0);
      case (rdy_mode)
        0: ev_hdr_ready_i = 1'b1;
        1: ev_hdr_ready_i = ($urandom_range(0, 2) != 0);
        default: ev_hdr_ready_i = 1'b0;
      endcase
      case (ack_mode)
        0: rd_ack_i = 1'b1;
        1: rd_ack_i = ($urandom_range(0, 2) != 0);
        default: rd_ack_i = 1'b0;
      endcase
    end
  end

  // Compare DUT transactions against the expected queue every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (ev_hdr_valid_o) begin
          nvec++;
          if (expq.size() == 0) begin
            nfail++;
            $display("FAIL hdr got dat=%h num=%0d want no header", ev_hdr_dat_o, ev_num_o);
          end else if (expq[0].kind != K_HDR || ev_hdr_dat_o !== expq[0].hdr || ev_num_o !== expq[0].num) begin
            nfail++;
            $display("FAIL hdr got dat=%h num=%0d want kind=%0d dat=%h num=%0d",
                     ev_hdr_dat_o, ev_num_o, expq[0].kind, expq[0].hdr, expq[0].num);
          end
          if (ev_hdr_ready_i && expq.size() > 0) void'(expq.pop_front());
        end
        if (rd_req_o) begin
          nvec++;
          if (expq.size() == 0) begin
            nfail++;
            $display("FAIL rd got blk=%0d want no read", rd_block_o);
          end else if (expq[0].kind != K_RD || rd_block_o !== expq[0].blk) begin
            nfail++;
            $display("FAIL rd got blk=%0d want kind=%0d blk=%0d", rd_block_o, expq[0].kind, expq[0].blk);
          end
          if (rd_ack_i && expq.size() > 0) void'(expq.pop_front());
        end
        if (free_req_o) begin
          nvec++;
          if (expq.size() == 0) begin
            nfail++;
            $display("FAIL free got blk=%0d want no free", free_block_o);
          end else begin
            if (expq[0].kind != K_FREE || free_block_o !== expq[0].blk || trunc_o !== expq[0].tr ||
                orphan_o !== expq[0].orp || ev_blocks_o !== expq[0].evb) begin
              nfail++;
              $display("FAIL free got blk=%0d tr=%b orp=%b evb=%0d want kind=%0d blk=%0d tr=%b orp=%b evb=%0d",
                       free_block_o, trunc_o, orphan_o, ev_blocks_o, expq[0].kind, expq[0].blk,
                       expq[0].tr, expq[0].orp, expq[0].evb);
            end
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    mon_en = 0;
    #2;
    rst_i = 1'b1;
    bq.delete();
    pend = 0;
    model_reset();
    @(negedge clk);
    #2;
    chk("reset_outs", {irs_buff_read_o, ev_hdr_dat_o, ev_num_o, ev_hdr_valid_o, rd_block_o,
                       rd_req_o, free_block_o, free_req_o, ev_blocks_o, trunc_o, orphan_o}, '0);
`ifdef IRS_SEQ_RD_TIMEOUT_EN
    chk("reset_timeout", timeout_o, 0);
`endif
    rst_i = 1'b0;
    mon_en = 1;
  endtask

  task automatic wait_cond(input int which, input int maxc, input string nm);
    bit hit;
    hit = 0;
    for (int i = 0; i < maxc && !hit; i++) begin
      @(negedge clk);
      #1;
      case (which)
        0: hit = ev_hdr_valid_o;
        1: hit = rd_req_o;
        2: hit = irs_buff_read_o;
        default: hit = free_req_o;
      endcase
    end
    nvec++;
    if (!hit) begin
      nfail++;
      $display("FAIL %s got no event after %0d cycles want event", nm, maxc);
    end
  endtask

  task automatic drain(input int maxc, input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      #1;
      done = (bq.size() == 0) && !pend && (expq.size() == 0) && !irs_buff_read_o &&
             !ev_hdr_valid_o && !rd_req_o && !free_req_o;
    end
    nvec++;
    if (!done) begin
      nfail++;
      $display("FAIL %s got pending=%0d expected transactions after %0d cycles want 0", nm, expq.size(), maxc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr_i = 1'b1;
    m_tr = 0;
    m_orp = 0;
    @(negedge clk);
    err_clr_i = 1'b0;
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [15:0] n;
    logic [71:0] e;

    model_reset();
    do_reset();

    // Two-event sequence with immediate handshakes.
    rdy_mode = 0; ack_mode = 0;
    push_entry(mk_entry(9'd5, 1'b1, 16'h0012, 32'h0000ABCD));
    push_entry(mk_entry(9'd6, 1'b0, 16'h0000, 32'h0));
    push_entry(mk_entry(9'd9, 1'b1, 16'h0777, 32'h12345678));
    wait_cond(0, 50, "hdr0_wait");
    chk("hdr0_dat", ev_hdr_dat_o, 64'h0000_0000_ABCD_0012);
    chk("hdr0_num", ev_num_o, 0);
    drain(200, "t1_drain");
    chk("t1_ev_blocks", ev_blocks_o, 2);
    chk("t1_ev_num", ev_num_o, 2);

    // Orphan continuation block right after reset.
    do_reset();
    push_entry(mk_entry(9'd3, 1'b0, 16'h0, 32'h0));
    drain(100, "t2_drain");
    chk("t2_orphan_set", orphan_o, 1);
    pulse_clr();
    chk("t2_orphan_clr", orphan_o, 0);

    // Oversize event: only MAXB blocks are read, all are freed.
    push_entry(mk_entry(9'd10, 1'b1, 16'h0042, 32'h00000010));
    push_entry(mk_entry(9'd11, 1'b0, 16'h0, 32'h0));
    push_entry(mk_entry(9'd12, 1'b0, 16'h0, 32'h0));
    push_entry(mk_entry(9'd13, 1'b0, 16'h0, 32'h0));
    drain(200, "t3_drain");
    chk("t3_trunc", trunc_o, 1);
    pulse_clr();
    chk("t3_trunc_clr", trunc_o, 0);

    // Clear coinciding with an orphan set: the set must win.
    do_reset();
    push_entry(mk_entry(9'd30, 1'b0, 16'h0, 32'h0));
    wait_cond(2, 50, "t_sw_pop");
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    drain(100, "t_sw_drain");
    chk("set_wins_orphan", orphan_o, 1);
    pulse_clr();

    // Header held off for 20 cycles.
    rdy_mode = 2;
    push_entry(mk_entry(9'd20, 1'b1, 16'h1234, 32'hCAFE0001));
    push_entry(mk_entry(9'd21, 1'b0, 16'h0, 32'h0));
    wait_cond(0, 50, "t4_hdr_wait");
    d = ev_hdr_dat_o;
    n = ev_num_o;
    chk("t4_hdr_dat", d, 64'h0000_CAFE_0001_1234);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("t4_hdr_hold", {ev_hdr_valid_o, ev_hdr_dat_o, ev_num_o, rd_req_o, irs_buff_read_o},
          {1'b1, d, n, 1'b0, 1'b0});
    end
    rdy_mode = 0;
    drain(200, "t4_drain");

    // Reset while a read request is outstanding.
    do_reset();
    ack_mode = 2;
    push_entry(mk_entry(9'd7, 1'b1, 16'h0007, 32'h7));
    wait_cond(1, 50, "t5_rd_wait");
    chk("t5_rd_block", rd_block_o, 7);
    do_reset();
    ack_mode = 0;
    push_entry(mk_entry(9'd8, 1'b1, 16'h0008, 32'h8));
    drain(100, "t5_drain");
    chk("t5_ev_num", ev_num_o, 1);

`ifdef IRS_SEQ_RD_TIMEOUT_EN
    // Read never acknowledged: watchdog frees the block uncounted.
    begin
      int c;
      push_entry(mk_entry(9'd2, 1'b1, 16'h0002, 32'h2));
      drain(100, "to_pre_drain");
      ack_mode = 2;
      mon_en = 0;
      bq.push_back(mk_entry(9'd4, 1'b0, 16'h0, 32'h0));
      wait_cond(1, 50, "to_rd_wait");
      c = 1;
      while (rd_req_o && c < 300) begin
        @(negedge clk);
        #1;
        if (rd_req_o) c++;
      end
      chk("to_req_cycles", c, TOC);
      chk("to_free", {free_req_o, free_block_o}, {1'b1, 9'd4});
      chk("to_flag", timeout_o, 1);
      @(negedge clk);
      #2;
      mon_en = 1;
      ack_mode = 0;
      push_entry(mk_entry(9'd9, 1'b1, 16'h0009, 32'h9));
      drain(100, "to_post_drain");
      chk("to_count_unchanged", ev_blocks_o, 1);
      pulse_clr();
      chk("to_clr", timeout_o, 0);
    end
`endif

    // Randomized traffic with random handshake timing.
    rdy_mode = 1;
    ack_mode = 1;
    for (int i = 0; i < 300; i++) begin
      e = {$urandom(), $urandom(), 8'($urandom_range(0, 255))};
      e[9] = ($urandom_range(0, 2) == 0);
      push_entry(e);
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    drain(20000, "rand_drain");
    chk("rand_trunc", trunc_o, m_tr);
    chk("rand_ev_num", ev_num_o, m_evnum);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
